// File: rtl/rs_symbol_packer.sv
// Serial-to-parallel input stage for the RS(255,223) syndrome calculator: ping-pong
// codeword buffer replayed as 16 uninterrupted 16-symbol beats. RS_CW_COUNT_EN adds cw_count.
module rs_symbol_packer #(
    parameter int N     = 255,
    parameter int W     = 8,
    parameter int LANES = 16,
    parameter int BEATS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         din_sop,
    output logic         din_ready,
    output logic [W-1:0] r0,
    output logic [W-1:0] r1,
    output logic [W-1:0] r2,
    output logic [W-1:0] r3,
    output logic [W-1:0] r4,
    output logic [W-1:0] r5,
    output logic [W-1:0] r6,
    output logic [W-1:0] r7,
    output logic [W-1:0] r8,
    output logic [W-1:0] r9,
    output logic [W-1:0] r10,
    output logic [W-1:0] r11,
    output logic [W-1:0] r12,
    output logic [W-1:0] r13,
    output logic [W-1:0] r14,
    output logic [W-1:0] r15,
    output logic         start,
    output logic         word_valid,
    output logic         burst_done,
    output logic         frame_err
`ifdef RS_CW_COUNT_EN
    ,
    output logic [15:0]  cw_count
`endif
);

    localparam int           PAD      = BEATS * LANES - N;
    localparam int           WORD_W   = LANES * W;
    localparam logic [7:0]   PAD_NEXT = 8'(PAD + 1);
    localparam logic [7:0]   LAST_IDX = 8'(BEATS * LANES - 1);
    localparam logic [3:0]   LAST_BT  = 4'(BEATS - 1);

    typedef enum logic {WR_WAIT_SOP, WR_FILL} wr_state_t;
    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

    logic [WORD_W-1:0] r_mem [0:1][0:BEATS-1];
    logic [1:0]        r_full;
    wr_state_t         r_wr_state;
    logic              r_wr_bank;
    logic [7:0]        r_wr_cnt;
    logic              r_frame_err;
    rd_state_t         r_rd_state;
    logic              r_rd_bank;
    logic [3:0]        r_beat;
    logic [WORD_W-1:0] r_word;
    logic              r_start;
    logic              r_word_valid;
    logic              r_burst_done;

    logic              w_accept;
    logic              w_sop_load;
    logic              w_sym_store;
    logic              w_drop;
    logic              w_fill_done;
    logic              w_burst_end;
    logic [3:0]        w_lane;
    logic [WORD_W-1:0] w_sop_word;

    // A bank is writable only once its previous contents have been fully burst out.
    assign din_ready   = ~r_full[r_wr_bank];
    assign w_accept    = din_valid & din_ready;
    assign w_sop_load  = w_accept & din_sop;
    assign w_sym_store = w_accept & ~din_sop & (r_wr_state == WR_FILL);
    assign w_drop      = w_accept & ~din_sop & (r_wr_state == WR_WAIT_SOP);
    assign w_fill_done = w_sym_store & (r_wr_cnt == LAST_IDX);
    assign w_burst_end = (r_rd_state == RD_BURST) & (r_beat == LAST_BT);
    assign w_lane      = ~r_wr_cnt[3:0];

    // The sop symbol rewrites all of beat 0 so the leading pad lanes are always zero.
    always_comb begin
        w_sop_word = '0;
        w_sop_word[(LANES - 1 - PAD) * W +: W] = din;
    end

    always_ff @(posedge clk) begin
        if (w_sop_load) begin
            r_mem[r_wr_bank][0] <= w_sop_word;
        end else if (w_sym_store) begin
            r_mem[r_wr_bank][r_wr_cnt[7:4]][int'(w_lane) * W +: W] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state  <= WR_WAIT_SOP;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_sop_load) begin
                r_frame_err <= (r_wr_state == WR_FILL);
                r_wr_cnt    <= PAD_NEXT;
                r_wr_state  <= WR_FILL;
            end else if (w_drop) begin
                r_frame_err <= 1'b1;
            end else if (w_sym_store) begin
                if (w_fill_done) begin
                    r_wr_state <= WR_WAIT_SOP;
                    r_wr_bank  <= ~r_wr_bank;
                    r_wr_cnt   <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 8'd1;
                end
            end
        end
    end

    // Fill and burst always target different banks, so set and clear never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            if (w_fill_done) begin
                r_full[r_wr_bank] <= 1'b1;
            end
            if (w_burst_end) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state   <= RD_IDLE;
            r_rd_bank    <= 1'b0;
            r_beat       <= '0;
            r_word       <= '0;
            r_start      <= 1'b0;
            r_word_valid <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_burst_done <= 1'b0;
            case (r_rd_state)
                RD_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_rd_state   <= RD_BURST;
                        r_beat       <= '0;
                        r_word       <= r_mem[r_rd_bank][0];
                        r_start      <= 1'b1;
                        r_word_valid <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (r_beat == LAST_BT) begin
                        r_rd_state   <= RD_IDLE;
                        r_word       <= '0;
                        r_word_valid <= 1'b0;
                        r_burst_done <= 1'b1;
                        r_rd_bank    <= ~r_rd_bank;
                    end else begin
                        r_beat <= r_beat + 4'd1;
                        r_word <= r_mem[r_rd_bank][r_beat + 4'd1];
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

`ifdef RS_CW_COUNT_EN
    logic [15:0] r_cw_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cw_count <= '0;
        end else if (w_burst_end) begin
            r_cw_count <= r_cw_count + 16'd1;
        end
    end

    assign cw_count = r_cw_count;
`endif

    assign start      = r_start;
    assign word_valid = r_word_valid;
    assign burst_done = r_burst_done;
    assign frame_err  = r_frame_err;

    // r15 carries the earliest (highest-degree) symbol of each beat.
    assign r0  = r_word[0*W  +: W];
    assign r1  = r_word[1*W  +: W];
    assign r2  = r_word[2*W  +: W];
    assign r3  = r_word[3*W  +: W];
    assign r4  = r_word[4*W  +: W];
    assign r5  = r_word[5*W  +: W];
    assign r6  = r_word[6*W  +: W];
    assign r7  = r_word[7*W  +: W];
    assign r8  = r_word[8*W  +: W];
    assign r9  = r_word[9*W  +: W];
    assign r10 = r_word[10*W +: W];
    assign r11 = r_word[11*W +: W];
    assign r12 = r_word[12*W +: W];
    assign r13 = r_word[13*W +: W];
    assign r14 = r_word[14*W +: W];
    assign r15 = r_word[15*W +: W];

endmodule

// File: tb/tb_rs_symbol_packer.sv
// Directed bench for rs_symbol_packer with a word scoreboard; define RS_CW_COUNT_EN
// to also check cw_count.
module tb_rs_symbol_packer;

    localparam int N   = 255;
    localparam int PAD = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_sop;
    logic        din_ready;
    logic [7:0]  r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0]  r8, r9, r10, r11, r12, r13, r14, r15;
    logic        start;
    logic        word_valid;
    logic        burst_done;
    logic        frame_err;
`ifdef RS_CW_COUNT_EN
    logic [15:0] cw_count;
`endif

    wire [127:0] r_all = {r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1, r0};

    rs_symbol_packer dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .din_ready  (din_ready),
        .r0 (r0),  .r1 (r1),  .r2 (r2),  .r3 (r3),
        .r4 (r4),  .r5 (r5),  .r6 (r6),  .r7 (r7),
        .r8 (r8),  .r9 (r9),  .r10(r10), .r11(r11),
        .r12(r12), .r13(r13), .r14(r14), .r15(r15),
        .start      (start),
        .word_valid (word_valid),
        .burst_done (burst_done),
        .frame_err  (frame_err)
`ifdef RS_CW_COUNT_EN
        ,
        .cw_count   (cw_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] exp_q[$];
    int           exp_start_q[$];
    int           start_log[$];
    logic [127:0] cap [0:15];
    logic [127:0] mon_ew;
    int           mon_es;
    int           n_vec = 0;
    int           n_err = 0;
    int           n_ferr = 0;
    int           n_done = 0;
    int           n_bursts = 0;
    int           mon_beat = 0;
    int           last_done_cyc = 0;
    bit           done_pend = 1'b0;
    bit           exp_done;
    logic [15:0]  exp_cw = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: compares every cycle against the scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            mon_beat  = 0;
            done_pend = 1'b0;
            exp_cw    = '0;
        end else begin
            exp_done  = done_pend;
            done_pend = 1'b0;
            check("burst_done", burst_done, exp_done);
            if (frame_err) n_ferr++;
            if (exp_done) begin
                n_done++;
                last_done_cyc = cyc;
`ifdef RS_CW_COUNT_EN
                exp_cw = exp_cw + 16'd1;
                check("cw_count", cw_count, exp_cw);
`endif
            end
            if (word_valid) begin
                check("start", start, mon_beat == 0);
                if (mon_beat == 0) begin
                    n_bursts++;
                    start_log.push_back(cyc);
                    if (exp_start_q.size() > 0) mon_es = exp_start_q.pop_front();
                    else mon_es = -1;
                    check("start_cycle", cyc, mon_es);
                end
                if (exp_q.size() > 0) mon_ew = exp_q.pop_front();
                else mon_ew = 'x;
                if (n_bursts == 1) cap[mon_beat] = r_all;
                check("word", r_all, mon_ew);
                mon_beat++;
                if (mon_beat == 16) begin
                    mon_beat  = 0;
                    done_pend = 1'b1;
                end
            end else begin
                check("idle_word", r_all, 128'd0);
                check("idle_start", start, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            din_valid = 1'b0;
            din_sop   = 1'b0;
            din       = 8'd0;
        end
    endtask

    task automatic drive_sym(input logic [7:0] d, input bit sop, output int t);
        int g = 0;
        tick();
        while (!din_ready && g < 2000) begin
            din_valid = 1'b0;
            din_sop   = 1'b0;
            tick();
            g++;
        end
        check("din_ready_wait", din_ready, 1'b1);
        din       = d;
        din_sop   = sop;
        din_valid = 1'b1;
        t         = cyc;
    endtask

    // kind 0: symbol i = i+1; otherwise random. abort_at > 0 sends that many junk
    // symbols first so the real sop lands mid-fill.
    task automatic send_cw(input int kind, input int abort_at, output int t_last);
        logic [7:0]   syms [0:254];
        logic [127:0] words [0:15];
        int           k;
        for (int j = 0; j < abort_at; j++) drive_sym(8'($urandom_range(0, 255)), j == 0, t_last);
        for (int i = 0; i < N; i++) begin
            syms[i] = (kind == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
            drive_sym(syms[i], i == 0, t_last);
        end
        for (int b = 0; b < 16; b++) words[b] = '0;
        for (int i = 0; i < N; i++) begin
            k = PAD + i;
            words[k / 16][(15 - k % 16) * 8 +: 8] = syms[i];
        end
        for (int b = 0; b < 16; b++) exp_q.push_back(words[b]);
        exp_start_q.push_back(t_last + 2);
    endtask

    task automatic wait_quiet();
        int g = 0;
        do begin
            idle(1);
            g++;
        end while ((exp_q.size() != 0 || done_pend || word_valid) && g < 3000);
        check("drain_timeout", g < 3000, 1'b1);
        if (g >= 3000) begin
            exp_q.delete();
            exp_start_q.delete();
        end
        idle(3);
    endtask

    initial begin
        int t_a, t_b1, t_b2, t;
        int b0, d0, f0;
        reset     = 1'b1;
        din       = 8'd0;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_done", burst_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_word", r_all, 128'd0);
        check("rst_ready", din_ready, 1'b1);
`ifdef RS_CW_COUNT_EN
        check("rst_cw_count", cw_count, 16'd0);
`endif
        tick();
        reset = 1'b0;
        idle(3);

        // Single ramp codeword: latency and lane placement.
        send_cw(0, -1, t_a);
        wait_quiet();
        check("a_bursts", n_bursts, 1);
        check("a_done_cycle", last_done_cyc, t_a + 18);
        check("a_w0_r15", cap[0][127:120], 8'h00);
        check("a_w0_r14", cap[0][119:112], 8'h01);
        check("a_w0_r0", cap[0][7:0], 8'h0F);
        check("a_w15_r15", cap[15][127:120], 8'hF0);
        check("a_w15_r0", cap[15][7:0], 8'hFF);

        // Two codewords with no input gap: each burst starts N cycles after the previous one.
        b0 = n_bursts;
        f0 = n_ferr;
        send_cw(1, -1, t_b1);
        send_cw(1, -1, t_b2);
        wait_quiet();
        check("b_bursts", n_bursts - b0, 2);
        check("b_no_frame_err", n_ferr - f0, 0);
        check("b_input_gap", t_b2 - t_b1, N);
        check("b_spacing", start_log[start_log.size() - 1] - start_log[start_log.size() - 2], N);

        // sop at symbol 100 of a fill restarts the codeword.
        b0 = n_bursts;
        f0 = n_ferr;
        send_cw(2, 100, t);
        wait_quiet();
        check("c_frame_err", n_ferr - f0, 1);
        check("c_bursts", n_bursts - b0, 1);

        // Stray symbol with no sop.
        b0 = n_bursts;
        f0 = n_ferr;
        tick();
        din       = 8'hAA;
        din_sop   = 1'b0;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 8'd0;
        check("d_frame_err_pulse", frame_err, 1'b1);
        check("d_ready", din_ready, 1'b1);
        idle(30);
        check("d_frame_err_once", n_ferr - f0, 1);
        check("d_no_burst", n_bursts - b0, 0);
        check("d_ready_after", din_ready, 1'b1);

        // Asynchronous reset while beat 7 is on the outputs.
        d0 = n_done;
        send_cw(1, -1, t);
        while (cyc < t + 9) idle(1);
        check("e_beat_before_reset", mon_beat, 7);
        #1;
        reset = 1'b1;
        #1;
        check("e_rst_word_valid", word_valid, 1'b0);
        check("e_rst_word", r_all, 128'd0);
        check("e_rst_ready", din_ready, 1'b1);
        exp_q.delete();
        exp_start_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        idle(20);
        check("e_no_done", n_done - d0, 0);
        send_cw(1, -1, t);
        wait_quiet();
        check("e_after_reset_done", n_done - d0, 1);
`ifdef RS_CW_COUNT_EN
        check("e_cw_count", cw_count, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
